// File: rtl/mem_arbiter.sv
// Two-port arbiter and sequencer for a single-port main memory.
// Grants one request at a time, issues it for one cycle, waits a fixed latency and returns a done pulse.
module mem_arbiter #(
    parameter int MEM_DEPTH   = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 1,
    parameter int ARB_MODE    = 0,
    localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              req,
    input  logic [1:0]              we,
    input  logic [2*AW-1:0]         addr,
    input  logic [2*DATA_WIDTH-1:0] wdata,
    output logic [1:0]              gnt,
    output logic [1:0]              done,
    output logic [1:0]              err,
    output logic [2*DATA_WIDTH-1:0] rdata,
    output logic                    mem_req_valid,
    output logic                    mem_we,
    output logic [AW-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY + 1) : 1;
    localparam logic [CW-1:0] LAT   = CW'(MEM_LATENCY);
    localparam logic [AW:0]   DEPTH = (AW + 1)'(MEM_DEPTH);

    state_t                  state;
    logic                    prio_ptr;
    logic                    cur_port;
    logic                    cur_we;
    logic                    cur_err;
    logic [CW-1:0]           lat_cnt;

    logic                    win;
    logic                    win_we;
    logic [AW-1:0]           win_addr;
    logic [DATA_WIDTH-1:0]   win_wdata;
    logic [1:0]              cur_onehot;

    // Winner selection is only meaningful while some req is high in IDLE.
    always_comb begin
        win = 1'b0;
        if (ARB_MODE == 1) begin
            win = ~req[0];
        end else begin
            win = req[prio_ptr] ? prio_ptr : ~prio_ptr;
        end
        win_we    = win ? we[1] : we[0];
        win_addr  = win ? addr[2*AW-1:AW] : addr[AW-1:0];
        win_wdata = win ? wdata[2*DATA_WIDTH-1:DATA_WIDTH] : wdata[DATA_WIDTH-1:0];
        gnt = 2'b00;
        if (state == S_IDLE && req != 2'b00) begin
            gnt = win ? 2'b10 : 2'b01;
        end
    end

    assign cur_onehot = cur_port ? 2'b10 : 2'b01;
    assign busy       = (state != S_IDLE);
    assign dbg_state  = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            prio_ptr      <= 1'b0;
            cur_port      <= 1'b0;
            cur_we        <= 1'b0;
            cur_err       <= 1'b0;
            lat_cnt       <= '0;
            done          <= 2'b00;
            err           <= 2'b00;
            rdata         <= '0;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
        end else begin
            done          <= 2'b00;
            err           <= 2'b00;
            mem_req_valid <= 1'b0;
            mem_we        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req != 2'b00) begin
                        cur_port <= win;
                        cur_we   <= win_we;
                        prio_ptr <= ~win;
                        // Out-of-range requests skip the memory; mem_addr/mem_wdata keep their old values.
                        if ({1'b0, win_addr} >= DEPTH) begin
                            cur_err <= 1'b1;
                            state   <= S_WAIT;
                        end else begin
                            cur_err       <= 1'b0;
                            mem_req_valid <= 1'b1;
                            mem_we        <= win_we;
                            mem_addr      <= win_addr;
                            mem_wdata     <= win_wdata;
                            state         <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    lat_cnt <= LAT;
                    state   <= S_WAIT;
                end
                S_WAIT: begin
                    if (cur_err || lat_cnt == CW'(1)) begin
                        done <= cur_onehot;
                        err  <= cur_err ? cur_onehot : 2'b00;
                        if (!cur_we) begin
                            if (cur_port) begin
                                rdata[2*DATA_WIDTH-1:DATA_WIDTH] <= cur_err ? '0 : mem_rdata;
                            end else begin
                                rdata[DATA_WIDTH-1:0] <= cur_err ? '0 : mem_rdata;
                            end
                        end
                        state <= S_IDLE;
                    end else begin
                        lat_cnt <= lat_cnt - CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a round-robin instance (depth 6, latency 1) and a fixed-priority
// instance (depth 8, latency 2), each with a behavioural memory and an expected-done queue.
module tb_mem_arbiter;

    localparam int DW    = 32;
    localparam int AW    = 3;
    localparam int FP_LAT = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    // round-robin instance signals
    logic [1:0]      rr_req = '0, rr_we = '0;
    logic [2*AW-1:0] rr_addr = '0;
    logic [2*DW-1:0] rr_wdata = '0;
    logic [1:0]      rr_gnt, rr_done, rr_err, rr_dbg;
    logic [2*DW-1:0] rr_rdata;
    logic            rr_mem_req_valid, rr_mem_we, rr_busy;
    logic [AW-1:0]   rr_mem_addr;
    logic [DW-1:0]   rr_mem_wdata, rr_mem_rdata;

    // fixed-priority instance signals
    logic [1:0]      fp_req = '0, fp_we = '0;
    logic [2*AW-1:0] fp_addr = '0;
    logic [2*DW-1:0] fp_wdata = '0;
    logic [1:0]      fp_gnt, fp_done, fp_err, fp_dbg;
    logic [2*DW-1:0] fp_rdata;
    logic            fp_mem_req_valid, fp_mem_we, fp_busy;
    logic [AW-1:0]   fp_mem_addr;
    logic [DW-1:0]   fp_mem_wdata, fp_mem_rdata;

    mem_arbiter #(.MEM_DEPTH(6), .DATA_WIDTH(DW), .MEM_LATENCY(1), .ARB_MODE(0)) u_rr (
        .clk(clk), .reset(reset), .req(rr_req), .we(rr_we), .addr(rr_addr), .wdata(rr_wdata),
        .gnt(rr_gnt), .done(rr_done), .err(rr_err), .rdata(rr_rdata),
        .mem_req_valid(rr_mem_req_valid), .mem_we(rr_mem_we), .mem_addr(rr_mem_addr),
        .mem_wdata(rr_mem_wdata), .mem_rdata(rr_mem_rdata), .busy(rr_busy), .dbg_state(rr_dbg)
    );

    mem_arbiter #(.MEM_DEPTH(8), .DATA_WIDTH(DW), .MEM_LATENCY(FP_LAT), .ARB_MODE(1)) u_fp (
        .clk(clk), .reset(reset), .req(fp_req), .we(fp_we), .addr(fp_addr), .wdata(fp_wdata),
        .gnt(fp_gnt), .done(fp_done), .err(fp_err), .rdata(fp_rdata),
        .mem_req_valid(fp_mem_req_valid), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr),
        .mem_wdata(fp_mem_wdata), .mem_rdata(fp_mem_rdata), .busy(fp_busy), .dbg_state(fp_dbg)
    );

    // behavioural memories: read data valid MEM_LATENCY cycles after the sampling edge
    logic [DW-1:0] rr_mem [8];
    logic [DW-1:0] fp_mem [8];
    logic [DW-1:0] rr_rd_q = '0;
    logic [DW-1:0] fp_rd1 = '0, fp_rd2 = '0;

    always @(posedge clk) begin
        if (rr_mem_req_valid) begin
            if (rr_mem_we) rr_mem[rr_mem_addr] <= rr_mem_wdata;
            else           rr_rd_q <= rr_mem[rr_mem_addr];
        end
        fp_rd2 <= fp_rd1;
        if (fp_mem_req_valid) begin
            if (fp_mem_we) fp_mem[fp_mem_addr] <= fp_mem_wdata;
            else           fp_rd1 <= fp_mem[fp_mem_addr];
        end
    end
    assign rr_mem_rdata = rr_rd_q;
    assign fp_mem_rdata = fp_rd2;

    // reference model state
    logic [DW-1:0] ref_mem [8];
    logic [DW-1:0] fp_ref_mem [8];
    logic [DW-1:0] ref_rd [2];
    logic [DW-1:0] fp_ref_rd [2];
    logic          rr_ptr;

    typedef struct packed {
        logic [1:0]      done;
        logic [1:0]      err;
        logic [2*DW-1:0] rdata;
        logic [31:0]     cyc;
    } exp_t;

    exp_t rr_q[$];
    exp_t fp_q[$];
    exp_t rr_rec, fp_rec;

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          exp_err;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboards: every done pulse must match the oldest expectation
    always @(negedge clk) begin
        if (rr_done !== 2'b00) begin
            if (rr_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rr_unexpected_done actual=%b required=00", rr_done);
            end else begin
                rr_rec = rr_q.pop_front();
                check("rr_done", 64'(rr_done), 64'(rr_rec.done));
                check("rr_err", 64'(rr_err), 64'(rr_rec.err));
                check("rr_rdata", rr_rdata, rr_rec.rdata);
                check("rr_done_cycle", 64'(cyc), 64'(rr_rec.cyc));
            end
        end
        if (fp_done !== 2'b00) begin
            if (fp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL fp_unexpected_done actual=%b required=00", fp_done);
            end else begin
                fp_rec = fp_q.pop_front();
                check("fp_done", 64'(fp_done), 64'(fp_rec.done));
                check("fp_err", 64'(fp_err), 64'(fp_rec.err));
                check("fp_rdata", fp_rdata, fp_rec.rdata);
                check("fp_done_cycle", 64'(cyc), 64'(fp_rec.cyc));
            end
        end
    end

    task automatic wait_rr_drain();
        for (int i = 0; i < 20; i++) begin
            if (rr_q.size() == 0) break;
            @(negedge clk);
        end
        check("rr_drain", 64'(rr_q.size()), 64'd0);
        rr_q.delete();
    endtask

    task automatic wait_fp_drain();
        for (int i = 0; i < 30; i++) begin
            if (fp_q.size() == 0) break;
            @(negedge clk);
        end
        check("fp_drain", 64'(fp_q.size()), 64'd0);
        fp_q.delete();
    endtask

    // one transaction on the round-robin instance, started from IDLE
    task automatic rr_txn(input logic port, input logic we, input logic [AW-1:0] a,
                          input logic [DW-1:0] wd, input logic exp_err, input logic [DW-1:0] exp_rd);
        logic [31:0] t;
        logic [1:0]  oh;
        exp_t        rec;
        oh = port ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        rr_req   = oh;
        rr_we    = port ? {we, ~we} : {~we, we};
        rr_addr  = port ? {a, ~a} : {~a, a};
        rr_wdata = port ? {wd, ~wd} : {~wd, wd};
        @(negedge clk);
        t = cyc;
        check("rr_gnt", 64'(rr_gnt), 64'(oh));
        if (rr_gnt == oh) begin
            ref_rd[port] = exp_rd;
            if (we && !exp_err) ref_mem[a] = wd;
            rr_ptr    = ~port;
            rec.done  = oh;
            rec.err   = exp_err ? oh : 2'b00;
            rec.rdata = {ref_rd[1], ref_rd[0]};
            rec.cyc   = t + (exp_err ? 32'd2 : 32'd3);
            rr_q.push_back(rec);
        end
        @(posedge clk); #1;
        rr_req = 2'b00;
        @(negedge clk);
        check("rr_busy", 64'(rr_busy), 64'd1);
        check("rr_mem_req_valid", 64'(rr_mem_req_valid), 64'(!exp_err));
        if (!exp_err) begin
            check("rr_mem_we", 64'(rr_mem_we), 64'(we));
            check("rr_mem_addr", 64'(rr_mem_addr), 64'(a));
            if (we) check("rr_mem_wdata", 64'(rr_mem_wdata), 64'(wd));
        end
        wait_rr_drain();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] init_vals [8];
        logic [31:0]   t;
        logic          w, p, we_r, e;
        logic [AW-1:0] a;
        logic [DW-1:0] wd, er;
        logic [1:0]    no_done;
        exp_t          rec;

        init_vals = '{32'h11110000, 32'h22221111, 32'h00730e33, 32'h44443333,
                      32'h55554444, 32'h66665555, 32'h77776666, 32'h88887777};
        for (int i = 0; i < 8; i++) begin
            rr_mem[i]     = init_vals[i];
            ref_mem[i]    = init_vals[i];
            fp_mem[i]     = 32'hF0000000 | (32'(i) * 32'h01010101);
            fp_ref_mem[i] = fp_mem[i];
        end
        ref_rd[0] = '0; ref_rd[1] = '0;
        fp_ref_rd[0] = '0; fp_ref_rd[1] = '0;
        rr_ptr = 1'b0;

        vecs[0] = '{1'b0, 1'b0, 3'd2, 32'h0,        1'b0, 32'h00730e33};
        vecs[1] = '{1'b1, 1'b1, 3'd5, 32'hDEADBEEF, 1'b0, 32'h00000000};
        vecs[2] = '{1'b1, 1'b0, 3'd5, 32'h0,        1'b0, 32'hDEADBEEF};
        vecs[3] = '{1'b0, 1'b0, 3'd7, 32'h0,        1'b1, 32'h00000000};
        vecs[4] = '{1'b1, 1'b1, 3'd6, 32'h12345678, 1'b1, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b0, 3'd0, 32'h0,        1'b0, 32'h11110000};
        vecs[6] = '{1'b1, 1'b0, 3'd6, 32'h0,        1'b1, 32'h00000000};
        vecs[7] = '{1'b0, 1'b1, 3'd3, 32'hCAFEF00D, 1'b0, 32'h11110000};
        vecs[8] = '{1'b1, 1'b0, 3'd3, 32'h0,        1'b0, 32'hCAFEF00D};

        // reset values
        #1;
        check("rst_gnt", 64'(rr_gnt), 64'd0);
        check("rst_done", 64'(rr_done), 64'd0);
        check("rst_err", 64'(rr_err), 64'd0);
        check("rst_rdata", rr_rdata, 64'd0);
        check("rst_mem_req_valid", 64'(rr_mem_req_valid), 64'd0);
        check("rst_mem_we", 64'(rr_mem_we), 64'd0);
        check("rst_mem_addr", 64'(rr_mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(rr_mem_wdata), 64'd0);
        check("rst_busy", 64'(rr_busy), 64'd0);
        check("rst_fp_busy", 64'(fp_busy), 64'd0);
        check("rst_fp_rdata", fp_rdata, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // directed table
        for (int i = 0; i < 9; i++) begin
            rr_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_err, vecs[i].exp_rdata);
        end

        // random transactions against the reference model
        for (int i = 0; i < 10; i++) begin
            p    = 1'($urandom_range(0, 1));
            we_r = 1'($urandom_range(0, 1));
            a    = AW'($urandom_range(0, 7));
            wd   = $urandom;
            e    = (a >= 3'd6);
            er   = we_r ? ref_rd[p] : (e ? 32'h0 : ref_mem[a]);
            rr_txn(p, we_r, a, wd, e, er);
        end

        // reset during WAIT of a port-1 read
        @(posedge clk); #1;
        rr_req = 2'b10; rr_we = 2'b00; rr_addr = {3'd3, 3'd0};
        @(negedge clk);
        check("wrst_gnt", 64'(rr_gnt), 64'b10);
        @(posedge clk); #1;
        rr_req = 2'b00;
        @(posedge clk); #1;
        check("wrst_busy_before", 64'(rr_busy), 64'd1);
        reset = 1'b1;
        #1;
        check("wrst_busy", 64'(rr_busy), 64'd0);
        check("wrst_done", 64'(rr_done), 64'd0);
        check("wrst_mem_req_valid", 64'(rr_mem_req_valid), 64'd0);
        check("wrst_rdata", rr_rdata, 64'd0);
        check("wrst_mem_addr", 64'(rr_mem_addr), 64'd0);
        ref_rd[0] = '0; ref_rd[1] = '0;
        fp_ref_rd[0] = '0; fp_ref_rd[1] = '0;
        rr_ptr = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        no_done = 2'b00;
        repeat (5) begin
            @(negedge clk);
            no_done |= rr_done;
        end
        check("wrst_no_done", 64'(no_done), 64'd0);

        // reset during ISSUE of a write: the write must not reach memory
        @(posedge clk); #1;
        rr_req = 2'b01; rr_we = 2'b01; rr_addr = {3'd0, 3'd4}; rr_wdata = {32'h0, 32'hBAD0BAD0};
        @(negedge clk);
        check("irst_gnt", 64'(rr_gnt), 64'b01);
        @(posedge clk); #1;
        rr_req = 2'b00; rr_we = 2'b00;
        @(negedge clk);
        check("irst_valid_before", 64'(rr_mem_req_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("irst_valid", 64'(rr_mem_req_valid), 64'd0);
        check("irst_mem_we", 64'(rr_mem_we), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        rr_txn(1'b1, 1'b0, 3'd4, 32'h0, 1'b0, ref_mem[4]);

        // round-robin contention: both ports read continuously
        @(posedge clk); #1;
        rr_req = 2'b11; rr_we = 2'b00; rr_addr = {3'd3, 3'd1};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            t = cyc;
            w = rr_ptr;
            check("rr_cont_gnt", 64'(rr_gnt), w ? 64'b10 : 64'b01);
            ref_rd[w] = ref_mem[w ? 3 : 1];
            rr_ptr    = ~w;
            rec.done  = w ? 2'b10 : 2'b01;
            rec.err   = 2'b00;
            rec.rdata = {ref_rd[1], ref_rd[0]};
            rec.cyc   = t + 32'd3;
            rr_q.push_back(rec);
            if (k < 3) begin
                repeat (2) begin
                    @(negedge clk);
                    check("rr_cont_gnt_idle", 64'(rr_gnt), 64'd0);
                end
            end
        end
        @(posedge clk); #1;
        rr_req = 2'b00;
        wait_rr_drain();

        // fixed-priority contention: port 0 keeps winning until it drops req
        @(posedge clk); #1;
        fp_req = 2'b11; fp_we = 2'b00; fp_addr = {3'd4, 3'd1};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            t = cyc;
            check("fp_cont_gnt0", 64'(fp_gnt), 64'b01);
            fp_ref_rd[0] = fp_ref_mem[1];
            rec.done  = 2'b01;
            rec.err   = 2'b00;
            rec.rdata = {fp_ref_rd[1], fp_ref_rd[0]};
            rec.cyc   = t + 32'(2 + FP_LAT);
            fp_q.push_back(rec);
            if (k == 2) begin
                @(posedge clk); #1;
                fp_req = 2'b10;
            end
            repeat (3) begin
                @(negedge clk);
                check("fp_cont_gnt_idle", 64'(fp_gnt), 64'd0);
            end
        end
        @(negedge clk);
        t = cyc;
        check("fp_cont_gnt1", 64'(fp_gnt), 64'b10);
        fp_ref_rd[1] = fp_ref_mem[4];
        rec.done  = 2'b10;
        rec.err   = 2'b00;
        rec.rdata = {fp_ref_rd[1], fp_ref_rd[0]};
        rec.cyc   = t + 32'(2 + FP_LAT);
        fp_q.push_back(rec);
        @(posedge clk); #1;
        fp_req = 2'b00;
        wait_fp_drain();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
